// File: rtl/mdv_ctrl.sv
// Microdrive CPU-side controller: synchronises the replay block's gap/rx_ready,
// queues received bytes in a FIFO, raises a gap interrupt and drives the select chain.
module mdv_ctrl #(
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic       cpu_addr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic       mdv_gap,
    input  logic       mdv_rx_ready,
    input  logic [7:0] mdv_din,
    output logic       mdv_sel,
    output logic       mdv_drive,
    output logic       gap_irq,
    input  logic       irq_ack
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic             gap_s1_q, gap_s2_q, gap_h_q;
    logic             rx_s1_q, rx_s2_q, rx_h_q;
    logic             gap_rise, rx_rise;

    logic [7:0]       sel_sr_q, sel_sr_d;
    logic             sel_clk_q, sel_clk_d;

    logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic             ovf_q, ovf_d;
    logic             irq_q, irq_d;
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       mem_q [DEPTH];

    logic             empty, full, ctrl_wr, flush, rd_data, do_pop, do_push;
    logic [7:0]       status;
    logic             unused_din;

    assign unused_din = &{1'b0, cpu_din[7:3]};

    // Two-flop synchronisers plus a history flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_s1_q <= 1'b0;
            gap_s2_q <= 1'b0;
            gap_h_q  <= 1'b0;
            rx_s1_q  <= 1'b0;
            rx_s2_q  <= 1'b0;
            rx_h_q   <= 1'b0;
        end else begin
            gap_s1_q <= mdv_gap;
            gap_s2_q <= gap_s1_q;
            gap_h_q  <= gap_s2_q;
            rx_s1_q  <= mdv_rx_ready;
            rx_s2_q  <= rx_s1_q;
            rx_h_q   <= rx_s2_q;
        end
    end

    assign gap_rise = gap_s2_q & ~gap_h_q;
    assign rx_rise  = rx_s2_q & ~rx_h_q;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                     (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign ctrl_wr = cpu_wr & ~cpu_addr;
    assign flush   = ctrl_wr & cpu_din[2];
    assign rd_data = cpu_rd & cpu_addr;
    assign do_pop  = rd_data & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = rx_rise & (~full | do_pop);

    assign mdv_sel   = sel_sr_q[0] | sel_sr_q[1];
    assign mdv_drive = sel_sr_q[0];
    assign gap_irq   = irq_q;
    assign cpu_dout  = dout_q;

    assign status = {2'b00, mdv_sel, full, irq_q, ovf_q, ~empty, gap_s2_q};

    always_comb begin
        sel_sr_d  = sel_sr_q;
        sel_clk_d = sel_clk_q;
        if (ctrl_wr) begin
            sel_clk_d = cpu_din[1];
            if (cpu_din[1] && !sel_clk_q)
                sel_sr_d = {sel_sr_q[6:0], cpu_din[0]};
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
        end else begin
            wptr_d = wptr_q + {{FIFO_AW{1'b0}}, do_push};
            rptr_d = rptr_q + {{FIFO_AW{1'b0}}, do_pop};
            if (rx_rise && full && !do_pop)
                ovf_d = 1'b1;
        end
    end

    always_comb begin
        irq_d = irq_q;
        if (gap_rise && mdv_sel)
            irq_d = 1'b1;
        else if (irq_ack)
            irq_d = 1'b0;
    end

    always_comb begin
        dout_d = dout_q;
        if (cpu_rd) begin
            if (cpu_addr)
                dout_d = empty ? 8'h00 : mem_q[rptr_q[FIFO_AW-1:0]];
            else
                dout_d = status;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_sr_q  <= '0;
            sel_clk_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            dout_q    <= 8'h00;
        end else begin
            sel_sr_q  <= sel_sr_d;
            sel_clk_q <= sel_clk_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
            dout_q    <= dout_d;
        end
    end

    // Storage needs no reset: contents are only visible behind the pointers
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem_q[wptr_q[FIFO_AW-1:0]] <= mdv_din;
    end

endmodule

// File: tb/tb_mdv_ctrl.sv
// Directed bench for mdv_ctrl: select chain, capture latency, overflow,
// full-with-pop, flush, gap interrupt and reset during a pulse.
module tb_mdv_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_addr = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic [7:0] cpu_dout;
    logic       mdv_gap = 1'b0, mdv_rx_ready = 1'b0;
    logic [7:0] mdv_din = 8'h00;
    logic       mdv_sel, mdv_drive, gap_irq;
    logic       irq_ack = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rd;

    mdv_ctrl #(.FIFO_AW(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .mdv_gap(mdv_gap), .mdv_rx_ready(mdv_rx_ready), .mdv_din(mdv_din),
        .mdv_sel(mdv_sel), .mdv_drive(mdv_drive),
        .gap_irq(gap_irq), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
        cyc(1);
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] d);
        cpu_rd = 1'b1; cpu_addr = a;
        cyc(1);
        cpu_rd = 1'b0;
        d = cpu_dout;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        mdv_din = b;
        mdv_rx_ready = 1'b1;
        cyc(4);
        mdv_rx_ready = 1'b0;
        cyc(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_dout", cpu_dout, 8'h00);
        chk("rst_irq", {7'd0, gap_irq}, 8'h00);
        chk("rst_sel", {7'd0, mdv_sel}, 8'h00);
        chk("rst_drive", {7'd0, mdv_drive}, 8'h00);

        // Select chain: shift 1 then 0 -> drive 2
        cpu_write(1'b0, 8'h01); cpu_write(1'b0, 8'h03);
        cpu_write(1'b0, 8'h00); cpu_write(1'b0, 8'h02);
        chk("selA_sel", {7'd0, mdv_sel}, 8'h01);
        chk("selA_drive", {7'd0, mdv_drive}, 8'h00);
        do_reset();
        cpu_write(1'b0, 8'h01); cpu_write(1'b0, 8'h03);
        chk("selB_sel", {7'd0, mdv_sel}, 8'h01);
        chk("selB_drive", {7'd0, mdv_drive}, 8'h01);

        // Capture with exact push latency
        do_reset();
        mdv_din = 8'hA5; mdv_rx_ready = 1'b1;
        cyc(2);
        cpu_rd = 1'b1; cpu_addr = 1'b0;
        cyc(1);
        chk("lat_edge3", cpu_dout, 8'h00);
        cyc(1);
        chk("lat_edge4", cpu_dout, 8'h02);
        cpu_rd = 1'b0; mdv_rx_ready = 1'b0;
        cyc(4);
        rx_pulse(8'h5A);
        rx_pulse(8'hFF);
        cpu_read(1'b1, rd); chk("cap0", rd, 8'hA5);
        cpu_read(1'b1, rd); chk("cap1", rd, 8'h5A);
        cpu_read(1'b1, rd); chk("cap2", rd, 8'hFF);
        cpu_read(1'b1, rd); chk("cap_empty", rd, 8'h00);
        cpu_read(1'b0, rd); chk("cap_stat", rd, 8'h00);

        // Overflow: 17 pushes, first 16 kept
        for (int i = 0; i < 17; i++) rx_pulse(8'h10 + 8'(i));
        cpu_read(1'b0, rd); chk("ovf_stat", rd, 8'h16);
        for (int i = 0; i < 16; i++) begin
            cpu_read(1'b1, rd); chk($sformatf("ovf_rd%0d", i), rd, 8'h10 + 8'(i));
        end
        cpu_read(1'b0, rd); chk("ovf_drained", rd, 8'h04);
        cpu_write(1'b0, 8'h04);
        cpu_read(1'b0, rd); chk("ovf_flush", rd, 8'h00);

        // Full FIFO with push coincident with pop
        for (int i = 0; i < 16; i++) rx_pulse(8'h40 + 8'(i));
        cpu_read(1'b0, rd); chk("full_stat", rd, 8'h12);
        mdv_din = 8'hC3; mdv_rx_ready = 1'b1;
        cyc(2);
        cpu_read(1'b1, rd); chk("full_pop", rd, 8'h40);
        cyc(1); mdv_rx_ready = 1'b0; cyc(4);
        cpu_read(1'b0, rd); chk("full_after", rd, 8'h12);
        for (int i = 1; i < 16; i++) begin
            cpu_read(1'b1, rd); chk($sformatf("full_rd%0d", i), rd, 8'h40 + 8'(i));
        end
        cpu_read(1'b1, rd); chk("full_last", rd, 8'hC3);
        cpu_read(1'b0, rd); chk("full_empty", rd, 8'h00);
        for (int i = 0; i < 3; i++) rx_pulse(8'h70 + 8'(i));
        cpu_write(1'b0, 8'h04);
        cpu_read(1'b0, rd); chk("flush_stat", rd, 8'h00);
        cpu_read(1'b1, rd); chk("flush_rd", rd, 8'h00);

        // Gap interrupt with drive 1 selected
        cpu_write(1'b0, 8'h01); cpu_write(1'b0, 8'h03);
        chk("irq_drive", {7'd0, mdv_drive}, 8'h01);
        cpu_read(1'b0, rd); chk("irq_stat0", rd, 8'h20);
        mdv_gap = 1'b1;
        cyc(2);
        chk("irq_early", {7'd0, gap_irq}, 8'h00);
        cyc(2);
        chk("irq_set", {7'd0, gap_irq}, 8'h01);
        mdv_gap = 1'b0; cyc(4);
        mdv_gap = 1'b1; cyc(2);
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        chk("irq_set_wins", {7'd0, gap_irq}, 8'h01);
        cpu_read(1'b0, rd); chk("irq_stat1", rd, 8'h29);
        cpu_write(1'b0, 8'h00); cpu_write(1'b0, 8'h02);
        cpu_write(1'b0, 8'h00); cpu_write(1'b0, 8'h02);
        chk("desel_sel", {7'd0, mdv_sel}, 8'h00);
        chk("desel_keep", {7'd0, gap_irq}, 8'h01);
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        chk("irq_ack", {7'd0, gap_irq}, 8'h00);
        mdv_gap = 1'b0; cyc(4);
        mdv_gap = 1'b1; cyc(6);
        chk("irq_nosel", {7'd0, gap_irq}, 8'h00);
        mdv_gap = 1'b0; cyc(4);

        // Reset in the middle of a pulse with 5 bytes queued
        cpu_write(1'b0, 8'h01); cpu_write(1'b0, 8'h03);
        for (int i = 0; i < 5; i++) rx_pulse(8'h90 + 8'(i));
        cpu_read(1'b0, rd); chk("mid_stat", rd, 8'h22);
        mdv_din = 8'hEE; mdv_rx_ready = 1'b1;
        cyc(1);
        reset = 1'b1; cyc(3);
        mdv_rx_ready = 1'b0; cyc(1);
        reset = 1'b0; cyc(6);
        chk("mid_irq", {7'd0, gap_irq}, 8'h00);
        chk("mid_sel", {7'd0, mdv_sel}, 8'h00);
        chk("mid_dout", cpu_dout, 8'h00);
        cpu_read(1'b0, rd); chk("mid_status", rd, 8'h00);
        cpu_read(1'b1, rd); chk("mid_data", rd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
